// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle RISC-V sequencer.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_BAD
  } iclass_e;

  typedef enum logic [1:0] {
    PC_SEQ, PC_BR, PC_JAL
  } pc_sel_e;

  function automatic iclass_e decode_op(input logic [6:0] op);
    iclass_e c;
    case (op)
      OP_R:    c = C_R;
      OP_I:    c = C_I;
      OP_LD:   c = C_LD;
      OP_ST:   c = C_ST;
      OP_BR:   c = C_BR;
      OP_JAL:  c = C_JAL;
      default: c = C_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_pc_next.sv
// Next-PC select: sequential, branch-taken, or JAL (offsets in halfwords).
module multicycle_pc_next
  import multicycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] jtarget_i,
  input  pc_sel_e         sel_i,
  output logic [XLEN-1:0] pc_o
);

  always_comb begin
    case (sel_i)
      PC_BR:   pc_o = pc_i + (imm_i << 1);
      PC_JAL:  pc_o = pc_i + (jtarget_i << 1);
      default: pc_o = pc_i + XLEN'(4);
    endcase
  end

endmodule

// File: rtl/multicycle_ctl.sv
// Multicycle sequencer: owns the PC and drives datapath controls from state.
// Define MULTICYCLE_CTL_PERF_EN to add the cycle/instret performance counters.
module multicycle_ctl
  import multicycle_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h28,
  parameter int              CNT_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jtarget,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            ir_load,
  output logic            reg_write,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem2reg,
  output logic [2:0]      alu_op,
  output logic [2:0]      state,
  output logic            illegal,
  output logic            retired
`ifdef MULTICYCLE_CTL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  state_e          state_q, state_d;
  iclass_e         cls_q, cls_d;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic            illegal_q, illegal_d;
  logic            boot_q;
  logic            pc_we;
  pc_sel_e         pc_sel;
  logic            unused_ins;

  assign unused_ins = ^ins[31:7];

  multicycle_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc_i      (pc_q),
    .imm_i     (imm),
    .jtarget_i (jtarget),
    .sel_i     (pc_sel),
    .pc_o      (pc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    pc_we     = 1'b0;
    pc_sel    = PC_SEQ;
    ir_load   = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem2reg   = 1'b0;
    alu_op    = 3'b000;
    retired   = 1'b0;
    case (state_q)
      S_FETCH: begin
        // The first cycle after reset is quiet so controls read all-zero.
        if (!boot_q) begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            cls_d   = decode_op(ins[6:0]);
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (cls_q == C_BAD) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            alu_op  = ALU_ADD;
            state_d = S_WB;
          end
          C_I, C_JAL: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
            state_d = S_WB;
          end
          C_LD, C_ST: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
            state_d = S_MEM;
          end
          C_BR: begin
            alu_op  = ALU_SUB;
            retired = 1'b1;
            pc_we   = 1'b1;
            if (zero) pc_sel = PC_BR;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (cls_q == C_ST) mem_write = 1'b1;
        else               mem_read  = 1'b1;
        if (mem_ready) begin
          if (cls_q == C_ST) begin
            // Store retires on the accepting cycle only, keeping retired a pulse.
            retired = 1'b1;
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        mem2reg   = (cls_q == C_LD);
        retired   = 1'b1;
        pc_we     = 1'b1;
        if (cls_q == C_JAL) pc_sel = PC_JAL;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      pc_q      <= RESET_PC;
      illegal_q <= 1'b0;
      boot_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      boot_q    <= 1'b0;
      if (pc_we) pc_q <= pc_nxt;
    end
  end

  assign pc      = pc_q;
  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef MULTICYCLE_CTL_PERF_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (retired) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctl.sv
// Scoreboard bench for multicycle_ctl; expected per-instruction results are queued at issue.
module tb_multicycle_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = '0, imm = '0, jtarget = '0;
  logic        zero = 1'b0, mem_ready = 1'b0;
  logic [31:0] pc;
  logic        ir_load, reg_write, alu_src, mem_read, mem_write, mem2reg, illegal, retired;
  logic [2:0]  alu_op, state;
`ifdef MULTICYCLE_CTL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctl dut (
    .clk(clk), .reset(reset), .ins(ins), .imm(imm), .jtarget(jtarget),
    .zero(zero), .mem_ready(mem_ready), .pc(pc), .ir_load(ir_load),
    .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .mem2reg(mem2reg), .alu_op(alu_op),
    .state(state), .illegal(illegal), .retired(retired)
`ifdef MULTICYCLE_CTL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    int          cyc;
    logic [23:0] tr;
    int          rd, rw, mw, m2r;
    logic [3:0]  ex;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0, n_ret = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] ctl();
    return {ir_load, reg_write, alu_src, mem_read, mem_write, mem2reg, alu_op, retired};
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_pc"}, pc, 32'h28);
    check({tag, "_ctl"}, 32'(ctl()), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
`ifdef MULTICYCLE_CTL_PERF_EN
    check({tag, "_cyc_cnt"}, cycle_cnt, 32'd0);
    check({tag, "_ret_cnt"}, instret_cnt, 32'd0);
`endif
  endtask

  task automatic run(input string nm, input logic [6:0] op, input logic [31:0] im, jt,
                     input logic z, input int fst, mst, input logic [31:0] epc, input int ecyc,
                     input logic [23:0] etr, input int erd, erw, emw, em2r, input logic [3:0] eex);
    exp_t e;
    int f = fst, m = mst, cyc = 0, rd = 0, rw = 0, mw = 0, m2r = 0, irl = 0;
    logic [23:0] tr = '0;
    logic [3:0]  ex = '0;
    bit done = 0;
    e.nm = nm; e.pc = epc; e.cyc = ecyc; e.tr = etr;
    e.rd = erd; e.rw = erw; e.mw = emw; e.m2r = em2r; e.ex = eex;
    sbq.push_back(e);
    ins = ($urandom() & 32'hFFFF_FF80) | {25'd0, op};
    imm = im; jtarget = jt; zero = z;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      if (state == 3'd0 && f > 0) begin mem_ready = 1'b0; f--; end
      else if (state == 3'd3 && m > 0) begin mem_ready = 1'b0; m--; end
      else mem_ready = 1'b1;
      @(negedge clk);
      cyc++;
      tr  = {tr[20:0], state};
      rd  += int'(mem_read);
      rw  += int'(reg_write);
      mw  += int'(mem_write);
      m2r += int'(mem2reg);
      irl += int'(ir_load);
      if (state == 3'd2) ex = {alu_src, alu_op};
      if (retired) done = 1;
    end
    e = sbq.pop_front();
    check({e.nm, "_retired"}, 32'(done), 32'd1);
    check({e.nm, "_cycles"}, 32'(cyc), 32'(e.cyc));
    check({e.nm, "_states"}, 32'(tr), 32'(e.tr));
    check({e.nm, "_mem_read"}, 32'(rd), 32'(e.rd));
    check({e.nm, "_reg_write"}, 32'(rw), 32'(e.rw));
    check({e.nm, "_mem_write"}, 32'(mw), 32'(e.mw));
    check({e.nm, "_mem2reg"}, 32'(m2r), 32'(e.m2r));
    check({e.nm, "_ir_load"}, 32'(irl), 32'd1);
    check({e.nm, "_exec"}, 32'(ex), 32'(e.ex));
    // Stall the next fetch one cycle so the new PC can be observed in FETCH.
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    check({e.nm, "_pc"}, pc, e.pc);
    check({e.nm, "_next_state"}, 32'(state), 32'd0);
    n_ret++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w, bad;
    logic [23:0] htr;
    do_reset("rst0");
    //    name          op     imm           jtarget       z  fst mst pc_after      cyc tr          rd rw mw m2r exec
    run("r_add",      7'h33, 32'h0,        32'h0,        1, 0, 0, 32'h2C,       4, 24'o0124,    1, 1, 0, 0, 4'b0010);
    run("jal_fwd",    7'h6F, 32'h0,        32'h2,        0, 0, 0, 32'h30,       4, 24'o0124,    1, 1, 0, 0, 4'b1010);
    run("jal_back",   7'h6F, 32'h0,        32'hFFFFFFFC, 1, 0, 0, 32'h28,       4, 24'o0124,    1, 1, 0, 0, 4'b1010);
    run("i_alu",      7'h13, 32'h0,        32'h0,        1, 0, 0, 32'h2C,       4, 24'o0124,    1, 1, 0, 0, 4'b1010);
    run("load_stall", 7'h03, 32'h0,        32'h0,        0, 0, 2, 32'h30,       7, 24'o0123334, 4, 1, 0, 1, 4'b1010);
    run("store",      7'h23, 32'h0,        32'h0,        1, 1, 0, 32'h34,       5, 24'o00123,   2, 0, 1, 0, 4'b1010);
    run("jal_40",     7'h6F, 32'h0,        32'h6,        0, 0, 0, 32'h40,       4, 24'o0124,    1, 1, 0, 0, 4'b1010);
    run("br_taken",   7'h63, 32'h8,        32'h0,        1, 0, 0, 32'h50,       3, 24'o012,     1, 0, 0, 0, 4'b0110);
    run("jal_to_40",  7'h6F, 32'h0,        32'hFFFFFFF8, 1, 0, 0, 32'h40,       4, 24'o0124,    1, 1, 0, 0, 4'b1010);
    run("br_not",     7'h63, 32'h8,        32'h0,        0, 0, 0, 32'h44,       3, 24'o012,     1, 0, 0, 0, 4'b0110);
    run("br_wrap",    7'h63, 32'h7FFFFFE0, 32'h0,        1, 0, 0, 32'h04,       3, 24'o012,     1, 0, 0, 0, 4'b0110);
    run("br_msb",     7'h63, 32'h80000010, 32'h0,        1, 0, 0, 32'h24,       3, 24'o012,     1, 0, 0, 0, 4'b0110);

    // Park a store in a MEM stall, then reset through it.
    ins = 32'h0000_0023;
    @(posedge clk); #1 mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    w = 0;
    while (state !== 3'd3 && w < 10) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_state", 32'(state), 32'd3);
    check("stall_mem_write", 32'(mem_write), 32'd1);
    check("stall_retired", 32'(retired), 32'd0);
`ifdef MULTICYCLE_CTL_PERF_EN
    check("pre_rst_instret", instret_cnt, 32'(n_ret));
`endif
    do_reset("rst_stall");

    // Illegal opcode: FETCH, DECODE, then ten frozen HALT cycles.
    ins = 32'h0000_007F;
    htr = '0; bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1 mem_ready = 1'b1;
      zero = c[0];
      @(negedge clk);
      if (c <= 3) htr = {htr[20:0], state};
      if (c == 2) check("ill_pre_flag", 32'(illegal), 32'd0);
      if (c >= 3 && (state !== 3'd5 || ctl() !== 10'd0 || pc !== 32'h28 || illegal !== 1'b1)) bad++;
    end
    check("ill_states", 32'(htr), 32'(24'o015));
    check("ill_halt_bad_cycles", 32'(bad), 32'd0);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_pc", pc, 32'h28);
`ifdef MULTICYCLE_CTL_PERF_EN
    check("ill_cycle_cnt", cycle_cnt, 32'd12);
    check("ill_instret_cnt", instret_cnt, 32'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
